// File: rtl/keypad_pkg.sv
// Shared types and key legend for the 4x4 keypad column scanner.
package keypad_pkg;

  typedef enum logic [1:0] {SETTLE, SAMPLE, HOLD} scan_state_t;

  localparam int SETTLE_CYCLES_DEF = 3000;

  // Indexed [row][col]; row r is rows_n bit r, col c is cols_n bit c.
  localparam logic [3:0] KEY_LEGEND [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic logic [3:0] legend(input logic [1:0] row, input logic [1:0] col);
    return KEY_LEGEND[row][col];
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the pulled-up keypad row inputs (idles at all-ones).
module keypad_row_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      dout <= '1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_controller.sv
// 4x4 keypad column scanner: settle, sample, hold-on-key.
// Build option KEYPAD_GHOST_REJECT_EN: multi-row presses are not treated as keys.
module keypad_scan_controller
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int CNT_W         = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rows_n,
  input  logic       scan_stop,
  output logic [3:0] cols_n,
  output logic       key_detected,
  output logic [3:0] key_code,
  output logic       scan_active
);

  scan_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       col_q, col_d;
  logic             det_q, det_d;
  logic [3:0]       code_q, code_d;
  logic [3:0]       rows_s;
  logic [3:0]       low;
  logic             hit;
  logic [1:0]       hit_row;

  keypad_row_sync #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (rows_n),
    .dout  (rows_s)
  );

  // Lowest-index low row wins when several are low.
  always_comb begin
    low     = ~rows_s;
    hit_row = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (low[i]) hit_row = 2'(i);
`ifdef KEYPAD_GHOST_REJECT_EN
    hit = (low != 4'b0000) && ((low & (low - 4'd1)) == 4'b0000);
`else
    hit = (low != 4'b0000);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SETTLE;
      cnt_q   <= '0;
      col_q   <= 2'd0;
      det_q   <= 1'b0;
      code_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      det_q   <= det_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    det_d   = det_q;
    code_d  = code_q;
    case (state_q)
      SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SAMPLE: begin
        if (hit) begin
          state_d = HOLD;
          det_d   = 1'b1;
          code_d  = legend(hit_row, col_q);
        end else begin
          state_d = SETTLE;
          col_d   = col_q + 2'd1;
        end
      end
      HOLD: begin
        det_d  = hit;
        code_d = hit ? legend(hit_row, col_q) : 4'h0;
        // scan_stop keeps the column parked even after the key is released.
        if (!hit && !scan_stop) begin
          state_d = SETTLE;
          col_d   = col_q + 2'd1;
        end
      end
      default: state_d = SETTLE;
    endcase
  end

  assign cols_n       = ~(4'b0001 << col_q);
  assign key_detected = det_q;
  assign key_code     = code_q;
  assign scan_active  = (state_q != HOLD);

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Directed self-checking bench for keypad_scan_controller with SETTLE_CYCLES=4.
module tb_keypad_scan_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] rows_n;
  logic       scan_stop;
  logic [3:0] cols_n;
  logic       key_detected;
  logic [3:0] key_code;
  logic       scan_active;

  int n_chk  = 0;
  int n_fail = 0;

  keypad_scan_controller #(.SETTLE_CYCLES(4), .CNT_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rows_n       (rows_n),
    .scan_stop    (scan_stop),
    .cols_n       (cols_n),
    .key_detected (key_detected),
    .key_code     (key_code),
    .scan_active  (scan_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the first negedge on which the wanted column is driven.
  task automatic wait_col(input logic [3:0] want);
    int n;
    n = 0;
    while (cols_n !== want && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wait_col", 8'(cols_n), 8'(want));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] e;
    rst_n     = 1'b0;
    rows_n    = 4'b1111;
    scan_stop = 1'b0;
    step(2);
    chk("rst_cols", 8'(cols_n), 8'h0E);
    chk("rst_det",  8'(key_detected), 8'h00);
    chk("rst_code", 8'(key_code), 8'h00);
    chk("rst_act",  8'(scan_active), 8'h01);
    rst_n = 1'b1;

    // 1: idle scan, 5-cycle stride per column, back to column 0 after 20 edges
    for (int n = 0; n <= 20; n++) begin
      if (n > 0) @(negedge clk);
      e = ~(4'b0001 << ((n / 5) % 4));
      chk("idle_cols", 8'(cols_n), 8'(e));
      chk("idle_det",  8'(key_detected), 8'h00);
    end

    // 2: row 1 on column 2 -> key 6, then row 2 on column 2 -> key 9
    wait_col(4'b1011);
    rows_n = 4'b1101;
    step(4);
    chk("t2_det_early", 8'(key_detected), 8'h00);
    step(1);
    chk("t2_det",  8'(key_detected), 8'h01);
    chk("t2_code", 8'(key_code), 8'h06);
    chk("t2_act",  8'(scan_active), 8'h00);
    step(3);
    chk("t2_frozen", 8'(cols_n), 8'h0B);
    rows_n = 4'b1011;
    step(2);
    chk("t2_code_old", 8'(key_code), 8'h06);
    step(1);
    chk("t2_code_9", 8'(key_code), 8'h09);
    chk("t2_det_9",  8'(key_detected), 8'h01);

    // 3: scan_stop holds the column through release and re-press
    scan_stop = 1'b1;
    rows_n    = 4'b1111;
    step(3);
    chk("t3_det_rel",  8'(key_detected), 8'h00);
    chk("t3_code_rel", 8'(key_code), 8'h00);
    step(4);
    chk("t3_frozen", 8'(cols_n), 8'h0B);
    chk("t3_act",    8'(scan_active), 8'h00);
    rows_n = 4'b1011;
    step(3);
    chk("t3_repress_det",  8'(key_detected), 8'h01);
    chk("t3_repress_code", 8'(key_code), 8'h09);
    rows_n = 4'b1111;
    step(3);
    chk("t3_det_rel2", 8'(key_detected), 8'h00);
    scan_stop = 1'b0;
    step(1);
    chk("t3_resume_cols", 8'(cols_n), 8'h07);
    chk("t3_resume_act",  8'(scan_active), 8'h01);

    // 4: row 3 on column 1 -> key 0, then row 0 -> key 2, release exits
    wait_col(4'b1101);
    rows_n = 4'b0111;
    step(5);
    chk("t4_det",  8'(key_detected), 8'h01);
    chk("t4_code", 8'(key_code), 8'h00);
    rows_n = 4'b1110;
    step(2);
    chk("t4_code_old", 8'(key_code), 8'h00);
    step(1);
    chk("t4_code_2", 8'(key_code), 8'h02);
    chk("t4_det_2",  8'(key_detected), 8'h01);
    rows_n = 4'b1111;
    step(3);
    chk("t4_det_rel",  8'(key_detected), 8'h00);
    chk("t4_exit_col", 8'(cols_n), 8'h0B);

    // 5: two rows low on column 0
    wait_col(4'b1110);
    rows_n = 4'b1100;
    step(5);
`ifdef KEYPAD_GHOST_REJECT_EN
    chk("t5_ghost_det",  8'(key_detected), 8'h00);
    chk("t5_ghost_cols", 8'(cols_n), 8'h0D);
`else
    chk("t5_multi_det",  8'(key_detected), 8'h01);
    chk("t5_multi_code", 8'(key_code), 8'h01);
    chk("t5_multi_cols", 8'(cols_n), 8'h0E);
`endif
    rows_n = 4'b1111;

    // 6: asynchronous reset while holding key A
    wait_col(4'b0111);
    rows_n = 4'b1110;
    step(5);
    chk("t6_det",  8'(key_detected), 8'h01);
    chk("t6_code", 8'(key_code), 8'h0A);
    scan_stop = 1'b1;
    step(2);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_cols", 8'(cols_n), 8'h0E);
    chk("t6_rst_det",  8'(key_detected), 8'h00);
    chk("t6_rst_code", 8'(key_code), 8'h00);
    chk("t6_rst_act",  8'(scan_active), 8'h01);
    rows_n    = 4'b1111;
    scan_stop = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(4);
    chk("t6_col0", 8'(cols_n), 8'h0E);
    step(1);
    chk("t6_col1", 8'(cols_n), 8'h0D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
